// File: rtl/sum_splitter.sv
// sum_splitter
// ------------
// Takes one IN_W-bit total over a valid/ready load port and drains it as a
// stream of OUT_W-bit chunks over a valid/ready out port. Every chunk is
// min(remaining, 2^OUT_W-1). Summing the chunks in order gives back the loaded
// total exactly. A zero total still produces one beat, with out_data = 0.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active low (0 = reset)
//   load_valid   producer offers load_total
//   load_ready   splitter is idle and out of reset, so it can take a total
//   load_total   total to drain
//   out_valid    out_data/out_last hold a chunk
//   out_ready    consumer takes the chunk
//   out_data     chunk value
//   out_last     final chunk of the current total
//   busy         a total is being drained
//   chunk_count  chunks accepted for the current or last total
//   done         one-cycle pulse after the last chunk is accepted
//
// sum_splitter_chk is a passive checker that watches the splitter's internal
// invariants. It is instantiated from the top and has no outputs.

module sum_splitter_chk #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             out_valid,
  input logic             out_ready,
  input logic [OUT_W-1:0] out_data,
  input logic             out_last,
  input logic             load_ready,
  input logic             done,
  input logic [IN_W-1:0]  remaining
);

  // An offered chunk stays put until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));

  // A chunk never exceeds what is left, so the subtraction cannot wrap.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    out_valid |-> ({{(IN_W-OUT_W){1'b0}}, out_data} <= remaining));

  // The final chunk carries exactly the remainder.
  a_last_exact: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && out_last) |-> ({{(IN_W-OUT_W){1'b0}}, out_data} == remaining));

  // Load and out sides never overlap.
  a_no_overlap: assert property (@(posedge clk) disable iff (!rst)
    !(load_ready && out_valid));

  // done appears only in an idle cycle.
  a_done_idle: assert property (@(posedge clk) disable iff (!rst)
    done |-> !out_valid);

endmodule

module sum_splitter #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [IN_W-1:0]  load_total,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] chunk_count,
  output logic             done
);

  // Largest chunk, widened to the total's width for comparisons.
  localparam logic [IN_W-1:0] CHUNK_MAX = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Chunk to emit for a given remainder: saturates at the chunk maximum.
  function automatic logic [OUT_W-1:0] chunk_of(input logic [IN_W-1:0] rem);
    if (rem > CHUNK_MAX) begin
      chunk_of = {OUT_W{1'b1}};
    end else begin
      chunk_of = rem[OUT_W-1:0];
    end
  endfunction

  // A remainder that fits in one chunk is the final chunk.
  function automatic logic is_last(input logic [IN_W-1:0] rem);
    is_last = (rem <= CHUNK_MAX);
  endfunction

  state_t             state_r,       state_nxt_s;
  logic [IN_W-1:0]    remaining_r,   remaining_nxt_s;
  logic               out_valid_r,   out_valid_nxt_s;
  logic [OUT_W-1:0]   out_data_r,    out_data_nxt_s;
  logic               out_last_r,    out_last_nxt_s;
  logic               busy_r,        busy_nxt_s;
  logic [CNT_W-1:0]   chunk_count_r, chunk_count_nxt_s;
  logic               done_r,        done_nxt_s;
  logic               load_ready_s;
  logic [IN_W-1:0]    rem_after_s;

  // What is left once the chunk on out_data has been taken. It is only used
  // on an out handshake, where out_data <= remaining always holds.
  assign rem_after_s = remaining_r - {{(IN_W-OUT_W){1'b0}}, out_data_r};

  // Next-state and next-output logic. Outputs are precomputed here so that
  // every out_* value comes from a register.
  always_comb begin
    state_nxt_s       = state_r;
    remaining_nxt_s   = remaining_r;
    out_valid_nxt_s   = out_valid_r;
    out_data_nxt_s    = out_data_r;
    out_last_nxt_s    = out_last_r;
    busy_nxt_s        = busy_r;
    chunk_count_nxt_s = chunk_count_r;
    done_nxt_s        = 1'b0;
    load_ready_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // Held low while rst is asserted, so a total offered during reset is
        // never taken.
        load_ready_s = rst;
        if (load_valid && rst) begin
          state_nxt_s       = ST_DRAIN;
          remaining_nxt_s   = load_total;
          out_valid_nxt_s   = 1'b1;
          out_data_nxt_s    = chunk_of(load_total);
          out_last_nxt_s    = is_last(load_total);
          busy_nxt_s        = 1'b1;
          chunk_count_nxt_s = {CNT_W{1'b0}};
        end else begin
          out_valid_nxt_s = 1'b0;
          busy_nxt_s      = 1'b0;
        end
      end

      ST_DRAIN: begin
        if (out_ready) begin
          remaining_nxt_s   = rem_after_s;
          chunk_count_nxt_s = chunk_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (out_last_r) begin
            state_nxt_s     = ST_IDLE;
            out_valid_nxt_s = 1'b0;
            out_data_nxt_s  = {OUT_W{1'b0}};
            out_last_nxt_s  = 1'b0;
            busy_nxt_s      = 1'b0;
            done_nxt_s      = 1'b1;
          end else begin
            out_data_nxt_s = chunk_of(rem_after_s);
            out_last_nxt_s = is_last(rem_after_s);
          end
        end else begin
          // Stalled: every output holds its value.
          out_valid_nxt_s = 1'b1;
        end
      end

      default: begin
        state_nxt_s     = ST_IDLE;
        remaining_nxt_s = {IN_W{1'b0}};
        out_valid_nxt_s = 1'b0;
        out_data_nxt_s  = {OUT_W{1'b0}};
        out_last_nxt_s  = 1'b0;
        busy_nxt_s      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      remaining_r   <= {IN_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_data_r    <= {OUT_W{1'b0}};
      out_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      chunk_count_r <= {CNT_W{1'b0}};
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      remaining_r   <= remaining_nxt_s;
      out_valid_r   <= out_valid_nxt_s;
      out_data_r    <= out_data_nxt_s;
      out_last_r    <= out_last_nxt_s;
      busy_r        <= busy_nxt_s;
      chunk_count_r <= chunk_count_nxt_s;
      done_r        <= done_nxt_s;
    end
  end

  assign load_ready  = load_ready_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_last    = out_last_r;
  assign busy        = busy_r;
  assign chunk_count = chunk_count_r;
  assign done        = done_r;

  sum_splitter_chk #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_valid  (out_valid_r),
    .out_ready  (out_ready),
    .out_data   (out_data_r),
    .out_last   (out_last_r),
    .load_ready (load_ready_s),
    .done       (done_r),
    .remaining  (remaining_r)
  );

endmodule

// File: tb/tb_sum_splitter.sv
// Testbench for sum_splitter. A reference model turns each total T into its
// expected chunk list: n = max(1, ceil(T/255)) beats, where every beat is 0xFF
// except the last, which is T - 255*(n-1). A saturating 16-bit accumulator
// sums the chunks the DUT emits, and that sum is compared with T.

module tb_sum_splitter;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [IN_W-1:0]  load_total;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [CNT_W-1:0] chunk_count;
  logic             done;

  int total_cnt = 0;
  int bad_cnt   = 0;

  sum_splitter #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_total  (load_total),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .chunk_count (chunk_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_data"},  32'(out_data),  32'd0);
    check_eq({tag, "_last"},  32'(out_last),  32'd0);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_done"},  32'(done),      32'd0);
    check_eq({tag, "_count"}, 32'(chunk_count), 32'd0);
  endtask

  // mode 0: out_ready held high; 1: random ready plus load noise during the
  // drain; 2: ready follows the repeating pattern 1,0,0,1
  task automatic run_total(input logic [15:0] t, input int mode);
    int n;
    int idx;
    int cyc;
    int acc;
    int exp_chunk;
    logic [3:0] pat;
    pat = 4'b1001;
    n = (int'(t) + 254) / 255;
    if (n == 0) n = 1;

    cyc = 0;
    while (!load_ready && cyc < 20) begin
      step();
      cyc++;
    end
    check_eq("load_ready_idle", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_total = t;
    out_ready  = 1'b0;
    step();
    load_valid = 1'b0;

    idx = 0;
    acc = 0;
    cyc = 0;
    while (idx < n && cyc < 3000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = pat[3 - (cyc % 4)];
      endcase
      if (mode == 1) begin
        load_valid = 1'($urandom_range(0, 1));
        load_total = 16'($urandom);
      end
      exp_chunk = (idx < n - 1) ? 255 : int'(t) - 255 * (n - 1);
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("out_data",  32'(out_data),  32'(exp_chunk));
      check_eq("out_last",  32'(out_last),  32'(idx == n - 1));
      check_eq("busy",      32'(busy),      32'd1);
      check_eq("count_run", 32'(chunk_count), 32'(idx));
      check_eq("load_ready_busy", 32'(load_ready), 32'd0);
      if (out_ready) begin
        acc += int'(out_data);
        idx++;
      end
      step();
      cyc++;
    end
    if (idx < n) check_eq("timeout", 32'(idx), 32'(n));
    load_valid = 1'b0;
    out_ready  = 1'b0;

    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("valid_end",  32'(out_valid), 32'd0);
    check_eq("busy_end",   32'(busy), 32'd0);
    check_eq("count_final", 32'(chunk_count), 32'(n));
    check_eq("load_ready_after", 32'(load_ready), 32'd1);
    check_eq("acc_sum", 32'((acc > 65535) ? 65535 : acc), 32'(t));
    check_eq("acc_no_sat", 32'(acc > 65535), 32'd0);
    // Idle with out_ready high must change nothing.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("done_once", 32'(done), 32'd0);
    check_eq("count_hold", 32'(chunk_count), 32'(n));
    check_eq("valid_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] rt_list [5];
    rt_list[0] = 16'h0001;
    rt_list[1] = 16'h00FF;
    rt_list[2] = 16'h0100;
    rt_list[3] = 16'hABCD;
    rt_list[4] = 16'hFFFF;

    rst        = 1'b0;
    load_valid = 1'b0;
    load_total = 16'h0000;
    out_ready  = 1'b0;
    step();
    step();
    check_all_zero("reset");
    check_eq("load_ready_in_reset", 32'(load_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("load_ready_release", 32'(load_ready), 32'd1);

    run_total(16'h0300, 0);
    run_total(16'h0000, 0);
    run_total(16'hFFFF, 0);
    run_total(16'h01FE, 2);

    // Reset in the middle of a drain, with a load offered while busy.
    load_valid = 1'b1;
    load_total = 16'h1234;
    step();
    load_total = 16'h5555;
    out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("mid_data", 32'(out_data), 32'hFF);
      check_eq("mid_count", 32'(chunk_count), 32'(i));
      step();
    end
    check_eq("ignored_load_count", 32'(chunk_count), 32'd3);
    check_eq("ignored_load_data", 32'(out_data), 32'hFF);
    check_eq("ignored_load_last", 32'(out_last), 32'd0);
    rst        = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b0;
    #1;
    check_eq("load_ready_rst", 32'(load_ready), 32'd0);
    step();
    check_all_zero("mid_reset");
    step();
    check_eq("no_done_after_rst", 32'(done), 32'd0);
    rst = 1'b1;
    #1;
    check_eq("load_ready_rerelease", 32'(load_ready), 32'd1);
    run_total(16'h0010, 0);

    // Round trip through the accumulator model, with random back-pressure.
    for (int i = 0; i < 5; i++) run_total(rt_list[i], 1);

    // Random totals, biased toward short ones, with random back-pressure.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 0) run_total(16'($urandom_range(0, 1100)), 1);
      else run_total(16'($urandom), 1);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule

// File: doc/sum_splitter.md
Name: sum_splitter

Overview:
- Inverse of the saturating accumulator: loads one 16-bit total and drains it as a stream of 8-bit chunks, each at most 0xFF.
- Feeding the emitted stream, in order, into the accumulator after its reset reproduces the loaded total exactly, with no saturation.
- Sits between a total producer (load side, valid/ready) and a byte consumer (out side, valid/ready).

Parameters:
- IN_W, 16, width of the loaded total.
- OUT_W, 8, width of each emitted chunk; chunk maximum is 2^OUT_W-1.
- CNT_W, 9, width of chunk_count; must hold ceil((2^IN_W-1)/(2^OUT_W-1)) = 257.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- load_valid  input  1  total offered.
- load_ready  output  1  splitter can accept a total.
- load_total  input  IN_W  total to drain.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  consumer accepts the chunk.
- out_data  output  OUT_W  chunk value.
- out_last  output  1  final chunk of the current total.
- busy  output  1  a total is being drained.
- chunk_count  output  CNT_W  chunks accepted for the current/last total.
- done  output  1  one-cycle pulse after the last chunk is accepted.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE; remaining=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0, chunk_count=0.
  - load_ready=0 while rst=0; load_ready=1 from the first cycle with rst=1.
- States: IDLE, DRAIN.
- IDLE:
  - load_ready=1, out_valid=0.
  - Load handshake (load_valid & load_ready) in cycle N: remaining<=load_total; chunk_count<=0; next state DRAIN.
  - out_valid=1 from cycle N+1 (1-cycle latency).
- DRAIN:
  - load_ready=0, busy=1, out_valid=1.
  - out_data = min(remaining, 2^OUT_W-1).
  - out_last = 1 iff remaining <= 2^OUT_W-1.
  - All out_* fields are registered and held stable while out_valid=1 and out_ready=0.
- Out handshake (out_valid & out_ready):
  - remaining <= remaining - out_data; chunk_count <= chunk_count+1.
  - If out_last: next state IDLE, done=1 for exactly the next cycle, chunk_count holds its final value until the next load.
- Zero total: emits exactly one chunk, out_data=0, out_last=1; every total produces at least one beat.
- Arithmetic:
  - Unsigned; remaining never underflows, because the chunk is always <= remaining.
  - Chunk count for total T: max(1, ceil(T/255)).
- Back-to-back totals:
  - A new load is accepted earliest in the cycle after the last handshake (IDLE).
  - There is no load/out overlap.
- Simultaneous events:
  - load_valid while busy is ignored (load_ready=0); load_total is not sampled.
  - out_ready while out_valid=0 has no effect.
- Reset mid-drain: abandons the remaining total immediately; the next cycle shows reset values; no done pulse.
- out_valid is never deasserted without a handshake, except by reset.

Test Plan:
- Load 0x0300, out_ready=1 -> out_data 0xFF,0xFF,0xFF,0x03 on consecutive cycles; out_last only on the 4th; done one cycle later; chunk_count=4.
- Load 0x0000 -> single beat, out_data=0x00, out_last=1; chunk_count=1; done pulse.
- Load 0xFFFF, out_ready=1 -> 257 beats of 0xFF, out_last on beat 257; chunk_count=257 (0x101).
- Load 0x01FE, out_ready toggling 1,0,0,1 -> out_data 0xFF held through the stall; second beat 0xFF with out_last=1; no beat lost or duplicated.
- Load 0x1234, assert load_valid with 0x5555 during DRAIN, drop rst to 0 after 3 beats:
  - the 0x5555 load is ignored;
  - after reset: all outputs 0, no done pulse;
  - after rst=1: load_ready=1, and a fresh load 0x0010 gives a single beat of 0x10.
- Round trip: drive the splitter output into the accumulator for totals {0x0001, 0x00FF, 0x0100, 0xABCD, 0xFFFF} -> accumulator sum equals each total after its last beat, with no saturation.
